// File: rtl/brg_vvadd_xcel_network_tx.sv
// brg_vvadd_xcel_network_tx: xcel master path to the manycore network (request reg, credits, load tags, response buffer); BRG_VVADD_XCEL_TX_TIMEOUT_EN adds a watchdog
module brg_vvadd_xcel_network_tx #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int max_out_credits_p = 16,
  parameter int num_tags_p = 4,
  localparam int tag_w_lp = $clog2(num_tags_p),
  localparam int mask_w_lp = data_width_p >> 3,
  localparam int cred_w_lp = $clog2(max_out_credits_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      tx_v_i,
  input  logic                      tx_we_i,
  input  logic [addr_width_p-1:0]   tx_addr_i,
  input  logic [data_width_p-1:0]   tx_data_i,
  input  logic [mask_w_lp-1:0]      tx_mask_i,
  input  logic [x_cord_width_p-1:0] tx_x_cord_i,
  input  logic [y_cord_width_p-1:0] tx_y_cord_i,
  output logic                      tx_ready_o,
  output logic [tag_w_lp-1:0]       tx_tag_o,
  output logic                      out_v_o,
  output logic                      out_we_o,
  output logic [addr_width_p-1:0]   out_addr_o,
  output logic [data_width_p-1:0]   out_data_o,
  output logic [mask_w_lp-1:0]      out_mask_o,
  output logic [x_cord_width_p-1:0] out_x_cord_o,
  output logic [y_cord_width_p-1:0] out_y_cord_o,
  output logic [x_cord_width_p-1:0] out_src_x_o,
  output logic [y_cord_width_p-1:0] out_src_y_o,
  output logic [tag_w_lp-1:0]       out_reg_id_o,
  input  logic                      out_ready_i,
  input  logic                      returned_v_i,
  input  logic                      returned_we_i,
  input  logic [data_width_p-1:0]   returned_data_i,
  input  logic [tag_w_lp-1:0]       returned_reg_id_i,
  output logic                      returned_yumi_o,
  output logic                      tx_resp_v_o,
  output logic [data_width_p-1:0]   tx_resp_data_o,
  output logic [tag_w_lp-1:0]       tx_resp_tag_o,
  input  logic                      tx_resp_ready_i,
  output logic                      idle_o,
  output logic                      err_timeout_o
);
  logic                      out_v_q, out_v_d, out_we_q;
  logic [addr_width_p-1:0]   out_addr_q;
  logic [data_width_p-1:0]   out_data_q, resp_data_q;
  logic [mask_w_lp-1:0]      out_mask_q;
  logic [x_cord_width_p-1:0] out_x_q;
  logic [y_cord_width_p-1:0] out_y_q;
  logic [tag_w_lp-1:0]       out_reg_id_q, resp_tag_q;
  logic                      resp_v_q, resp_v_d;
  logic [cred_w_lp-1:0]      credits_q, credits_d;
  logic [num_tags_p-1:0]     busy_q, busy_d, alloc_oh, free_oh;
  logic                      any_free, accept, ld_in, resp_fire;

  always_comb begin
    tx_tag_o = '0;
    for (int i = num_tags_p - 1; i >= 0; i--)
      if (!busy_q[i]) tx_tag_o = tag_w_lp'(i);
  end

  assign any_free        = ~&busy_q;
  assign tx_ready_o      = (~out_v_q | out_ready_i) & (credits_q < cred_w_lp'(max_out_credits_p)) & (tx_we_i | any_free);
  assign accept          = tx_v_i & tx_ready_o;
  assign returned_yumi_o = returned_v_i & (returned_we_i | ~resp_v_q | tx_resp_ready_i);
  assign ld_in           = returned_yumi_o & ~returned_we_i;
  assign resp_fire       = resp_v_q & tx_resp_ready_i;

  // a tag freed this cycle stays busy for allocation until the next cycle
  assign alloc_oh  = (accept & ~tx_we_i) ? num_tags_p'(1) << tx_tag_o : '0;
  assign free_oh   = resp_fire ? num_tags_p'(1) << resp_tag_q : '0;
  assign busy_d    = (busy_q & ~free_oh) | alloc_oh;
  assign out_v_d   = accept | (out_v_q & ~out_ready_i);
  assign resp_v_d  = ld_in | (resp_v_q & ~tx_resp_ready_i);
  assign credits_d = credits_q + cred_w_lp'(accept) - cred_w_lp'(returned_yumi_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_v_q   <= 1'b0;
      resp_v_q  <= 1'b0;
      credits_q <= '0;
      busy_q    <= '0;
    end else begin
      out_v_q   <= out_v_d;
      resp_v_q  <= resp_v_d;
      credits_q <= credits_d;
      busy_q    <= busy_d;
    end
    if (accept) begin
      out_we_q     <= tx_we_i;
      out_addr_q   <= tx_addr_i;
      out_data_q   <= tx_data_i;
      out_mask_q   <= tx_mask_i;
      out_x_q      <= tx_x_cord_i;
      out_y_q      <= tx_y_cord_i;
      out_reg_id_q <= tx_we_i ? '0 : tx_tag_o;
    end
    if (ld_in) begin
      resp_data_q <= returned_data_i;
      resp_tag_q  <= returned_reg_id_i;
    end
  end

  assign out_v_o        = out_v_q;
  assign out_we_o       = out_we_q;
  assign out_addr_o     = out_addr_q;
  assign out_data_o     = out_data_q;
  assign out_mask_o     = out_mask_q;
  assign out_x_cord_o   = out_x_q;
  assign out_y_cord_o   = out_y_q;
  assign out_src_x_o    = my_x_i;
  assign out_src_y_o    = my_y_i;
  assign out_reg_id_o   = out_reg_id_q;
  assign tx_resp_v_o    = resp_v_q;
  assign tx_resp_data_o = resp_data_q;
  assign tx_resp_tag_o  = resp_tag_q;
  assign idle_o         = ~out_v_q & ~resp_v_q & (credits_q == '0);

`ifdef BRG_VVADD_XCEL_TX_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
  assign wd_d  = (credits_q == '0 || returned_yumi_o) ? '0 : (&wd_q ? wd_q : wd_q + 16'd1);
  assign err_d = err_q | (&wd_q);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i && returned_v_i) begin
      if (!returned_we_i && !busy_q[returned_reg_id_i]) $error("returned load for free tag %0d", returned_reg_id_i);
      if (credits_q == '0) $error("response with no outstanding credit");
    end
  end
`endif
endmodule

// File: tb/tb_brg_vvadd_xcel_network_tx.sv
// tb_brg_vvadd_xcel_network_tx: directed and random stimulus checked against a queue-based model of the tx path
module tb_brg_vvadd_xcel_network_tx;
  localparam int DW = 32, AW = 28, XW = 4, YW = 4, NT = 4, MC = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    mask;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    tag;
  } req_t;

  typedef struct packed {
    logic          we;
    logic [1:0]    tag;
    logic [DW-1:0] data;
  } net_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [XW-1:0] my_x = 4'd5;
  logic [YW-1:0] my_y = 4'd9;
  logic tx_v = 0, tx_we = 0, tx_ready;
  logic [AW-1:0] tx_addr = '0, out_addr;
  logic [DW-1:0] tx_data = '0, out_data, ret_data = '0, resp_data;
  logic [3:0] tx_mask = '0, out_mask;
  logic [XW-1:0] tx_x = '0, out_x, out_sx;
  logic [YW-1:0] tx_y = '0, out_y, out_sy;
  logic [1:0] tx_tag, out_reg_id, ret_id = '0, resp_tag;
  logic out_v, out_we, out_ready = 1'b1;
  logic ret_v = 0, ret_we = 0, yumi;
  logic resp_v, resp_ready = 1'b1, idle, err;

  always #5 clk = ~clk;

  brg_vvadd_xcel_network_tx #(
    .data_width_p(DW), .addr_width_p(AW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .max_out_credits_p(MC), .num_tags_p(NT)
  ) dut (
    .clk_i(clk), .reset_i(rst), .my_x_i(my_x), .my_y_i(my_y),
    .tx_v_i(tx_v), .tx_we_i(tx_we), .tx_addr_i(tx_addr), .tx_data_i(tx_data), .tx_mask_i(tx_mask),
    .tx_x_cord_i(tx_x), .tx_y_cord_i(tx_y), .tx_ready_o(tx_ready), .tx_tag_o(tx_tag),
    .out_v_o(out_v), .out_we_o(out_we), .out_addr_o(out_addr), .out_data_o(out_data), .out_mask_o(out_mask),
    .out_x_cord_o(out_x), .out_y_cord_o(out_y), .out_src_x_o(out_sx), .out_src_y_o(out_sy),
    .out_reg_id_o(out_reg_id), .out_ready_i(out_ready),
    .returned_v_i(ret_v), .returned_we_i(ret_we), .returned_data_i(ret_data), .returned_reg_id_i(ret_id),
    .returned_yumi_o(yumi), .tx_resp_v_o(resp_v), .tx_resp_data_o(resp_data), .tx_resp_tag_o(resp_tag),
    .tx_resp_ready_i(resp_ready), .idle_o(idle), .err_timeout_o(err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // model state: request waiting for the network, requests in the network, buffered response
  req_t slot_q[$];
  net_t net_q[$];
  net_t resp_q[$];
  int credits = 0, wd = 0, sel = 0;
  bit [NT-1:0] busy = '0;
  bit model_ok = 0, m_err = 0;
  logic e_ready, e_yumi, e_free;
  logic [1:0] e_tag;

  function automatic bit m_idle();
    return slot_q.size() == 0 && resp_q.size() == 0 && credits == 0;
  endfunction

  always @(negedge clk) begin
    #2;
    if (model_ok) begin
      e_free = 0;
      e_tag = '0;
      for (int i = NT - 1; i >= 0; i--) if (!busy[i]) begin e_free = 1; e_tag = 2'(i); end
      e_ready = (slot_q.size() == 0 || out_ready) && credits < MC && (tx_we || e_free);
      e_yumi = ret_v && (ret_we || resp_q.size() == 0 || resp_ready);
      chk("tx_ready", tx_ready, e_ready);
      if (e_free) chk("tx_tag", tx_tag, e_tag);
      chk("yumi", yumi, e_yumi);
      chk("out_v", out_v, slot_q.size());
      if (slot_q.size() != 0) begin
        chk("out_we", out_we, slot_q[0].we);
        chk("out_addr", out_addr, slot_q[0].addr);
        chk("out_data", out_data, slot_q[0].data);
        chk("out_mask", out_mask, slot_q[0].mask);
        chk("out_xy", {out_x, out_y}, {slot_q[0].x, slot_q[0].y});
        chk("out_reg_id", out_reg_id, slot_q[0].tag);
      end
      chk("out_src", {out_sx, out_sy}, {my_x, my_y});
      chk("resp_v", resp_v, resp_q.size());
      if (resp_q.size() != 0) begin
        chk("resp_data", resp_data, resp_q[0].data);
        chk("resp_tag", resp_tag, resp_q[0].tag);
      end
      chk("idle", idle, m_idle());
      chk("err", err, m_err);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      slot_q.delete(); net_q.delete(); resp_q.delete();
      credits = 0; busy = '0; wd = 0; m_err = 0; model_ok = 1;
    end else if (model_ok) begin
`ifdef BRG_VVADD_XCEL_TX_TIMEOUT_EN
      if (wd == 65535) m_err = 1;
      wd = (credits == 0 || e_yumi) ? 0 : (wd == 65535 ? wd : wd + 1);
`endif
      if (resp_q.size() != 0 && resp_ready) begin
        busy[resp_q[0].tag] = 0;
        void'(resp_q.pop_front());
      end
      if (e_yumi) begin
        if (!net_q[sel].we) resp_q.push_back(net_q[sel]);
        net_q.delete(sel);
      end
      if (slot_q.size() != 0 && out_ready) begin
        net_q.push_back('{we: slot_q[0].we, tag: slot_q[0].tag, data: $urandom});
        void'(slot_q.pop_front());
      end
      if (tx_v && e_ready) begin
        if (!tx_we) busy[e_tag] = 1;
        slot_q.push_back('{we: tx_we, addr: tx_addr, data: tx_data, mask: tx_mask, x: tx_x, y: tx_y,
                           tag: tx_we ? 2'd0 : e_tag});
      end
      credits = credits + int'(tx_v && e_ready) - int'(e_yumi);
    end
  end

  task automatic tx(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    tx_v = v; tx_we = we; tx_addr = a; tx_data = d; tx_mask = 4'hF; tx_x = 4'd2; tx_y = 4'd3;
  endtask

  task automatic ret(input int i);
    sel = i; ret_v = 1; ret_we = net_q[i].we; ret_id = net_q[i].tag; ret_data = net_q[i].data;
  endtask

  task automatic ret_tag(input logic [1:0] t);
    int idx = -1;
    foreach (net_q[i]) if (!net_q[i].we && net_q[i].tag == t && idx < 0) idx = i;
    if (idx < 0) begin
      checks++; errors++; ret_v = 0;
      $display("FAIL ret_tag: load tag %0d not outstanding in network, expected present", t);
    end else ret(idx);
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (m_idle()) done = 1;
      tx(0, 0, '0, '0); out_ready = 1; resp_ready = 1;
      if (!done && net_q.size() != 0) ret(0); else ret_v = 0;
    end
    #3;
    chk("drain_idle", idle, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    #3;
    chk("rst_out_v", out_v, 0);
    chk("rst_resp_v", resp_v, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    chk("rst_ready", tx_ready, 1);
    // single store
    @(negedge clk); tx(1, 1, 'h100, 'hDEAD); out_ready = 1; #3; chk("st_ready", tx_ready, 1);
    @(negedge clk); tx(0, 0, '0, '0); #3;
    chk("st_out_v", out_v, 1); chk("st_addr", out_addr, 'h100); chk("st_data", out_data, 'hDEAD); chk("st_reg_id", out_reg_id, 0);
    @(negedge clk); ret(0); #3; chk("st_yumi", yumi, 1);
    @(negedge clk); ret_v = 0; #3; chk("st_idle", idle, 1);
    // four loads then tags exhausted
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); tx(1, 0, AW'(i * 4), '0); #3;
      chk("ld_tag", tx_tag, i); chk("ld_ready", tx_ready, 1);
    end
    @(negedge clk); tx(1, 0, 'h40, '0); #3; chk("ld5_ready", tx_ready, 0);
    @(negedge clk); tx(1, 1, 'h44, 'h77); #3; chk("st_tags_full_ready", tx_ready, 1);
    // out-of-order returns into a stalled response buffer
    @(negedge clk); tx(0, 0, '0, '0); resp_ready = 0; ret_tag(2); #3; chk("ret2_yumi", yumi, 1);
    @(negedge clk); ret_tag(0); #3; chk("ret0_stall", yumi, 0); chk("buf_v", resp_v, 1); chk("buf_tag", resp_tag, 2);
    @(negedge clk); ret_tag(0); #3; chk("ret0_stall2", yumi, 0);
    @(negedge clk); resp_ready = 1; ret_tag(0); #3; chk("ret0_yumi", yumi, 1);
    @(negedge clk); ret_v = 0; #3; chk("buf_tag0", resp_tag, 0);
    drain();
    // credit limit
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); tx(1, 1, AW'($urandom), $urandom); out_ready = 1; #3; chk("cr_ready", tx_ready, 1);
    end
    @(negedge clk); tx(1, 1, 'h5, 'h5); #3; chk("cr17_ready", tx_ready, 0);
    @(negedge clk); tx(0, 0, '0, '0); ret(0); #3; chk("cr_ack", yumi, 1);
    @(negedge clk); tx(1, 1, 'h6, 'h6); ret(0); #3; chk("cr_both_ready", tx_ready, 1); chk("cr_both_yumi", yumi, 1);
    @(negedge clk); ret_v = 0; tx(1, 1, 'h7, 'h7); #3; chk("cr_15_ready", tx_ready, 1);
    @(negedge clk); tx(1, 1, 'h8, 'h8); #3; chk("cr_16_ready", tx_ready, 0);
    drain();
    // network backpressure, then reset mid-transfer
    @(negedge clk); tx(1, 1, 'h2A, 'h55); out_ready = 0; #3; chk("bp_ready0", tx_ready, 1);
    repeat (5) begin
      @(negedge clk); tx(1, 1, 'h3B, 'h66); out_ready = 0; #3;
      chk("bp_out_v", out_v, 1); chk("bp_addr", out_addr, 'h2A); chk("bp_data", out_data, 'h55); chk("bp_ready", tx_ready, 0);
    end
    @(negedge clk); rst = 1; tx(0, 0, '0, '0); out_ready = 1;
    @(negedge clk); rst = 0; #3;
    chk("mrst_out_v", out_v, 0); chk("mrst_idle", idle, 1); chk("mrst_resp_v", resp_v, 0); chk("mrst_ready", tx_ready, 1);
    // random traffic
    repeat (3000) begin
      @(negedge clk);
      tx($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom), $urandom);
      tx_mask = 4'($urandom); tx_x = 4'($urandom); tx_y = 4'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      resp_ready = $urandom_range(0, 9) < 6;
      if (net_q.size() != 0 && $urandom_range(0, 1) == 1) ret(int'($urandom_range(0, net_q.size() - 1)));
      else ret_v = 0;
    end
    drain();
`ifdef BRG_VVADD_XCEL_TX_TIMEOUT_EN
    @(negedge clk); tx(1, 0, 'h200, '0); out_ready = 1; #3; chk("to_ready", tx_ready, 1);
    @(negedge clk); tx(0, 0, '0, '0);
    for (int n = 0; n < 65600 && err !== 1'b1; n++) @(negedge clk);
    #3; chk("to_err", err, 1);
    @(negedge clk); if (net_q.size() != 0) ret(0); #3; chk("to_late_yumi", yumi, 1);
    @(negedge clk); ret_v = 0;
    repeat (3) @(negedge clk);
    #3; chk("to_sticky", err, 1);
    drain();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
